multiword_adder: RTL
====================

# multiword_adder

Sequential multi-precision two's-complement adder that sums two WORDS×bits-wide operands one bits-wide word per accepted beat, least-significant word first, propagating the carry between beats in a register. It is the additive counterpart to the ALU's single-cycle subtractor. It emits one sum word per beat and publishes the same N, V and Co flag set on the final word, plus an optional Z flag. It sits beside the ALU datapath for operands wider than the native word.

## Interface
- bits, 4: word width per beat.
- WORDS, 4: beats per operation; total operand width is WORDS*bits; WORDS ≥ 2.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  begins an operation; honoured only in IDLE.
- cin  input  1  initial carry-in, sampled with start.
- in_valid  input  1  A/B word present this cycle.
- A  input  bits  operand A word, signed on the final beat.
- B  input  bits  operand B word, signed on the final beat.
- busy  output  1  high in RUN.
- S  output  bits  registered sum word.
- s_valid  output  1  S holds a new word this cycle.
- done  output  1  one-cycle pulse with the final sum word.
- Co  output  1  carry out of the most-significant word.
- N  output  1  sign of the full result (MSB of final word).
- V  output  1  signed overflow of the full result.
- Z  output  1  whole result equal to zero.

## Operation
- States: IDLE, RUN, DONE; encoding is free.
- IDLE: start=1 latches cin into the carry register, clears the beat counter and the zero accumulator, then goes to RUN. start=0 stays in IDLE.
- RUN, in_valid=1: compute the (bits+1)-bit value {c,s} = A + B + carry.
  - S ← s, s_valid ← 1, carry ← c, counter increments.
  - The zero accumulator ORs in s.
- RUN, in_valid=0: stall. No state change, s_valid ← 0.
- RUN, counter = WORDS-1 with in_valid=1 (final beat):
  - Co ← c.
  - N ← s[bits-1].
  - V ← (carry into bit bits-1) XOR c.
  - Z ← ~(acc | s).
  - done ← 1; go to DONE.
- DONE: lasts one cycle; s_valid and done high; return to IDLE.
- start outside IDLE is ignored. A, B and in_valid outside RUN are ignored.
- Co, N, V and Z hold their values until the final beat of the next operation updates them; they do not change at start.
- Arithmetic is modulo 2^bits per word. Only the final beat's carry and overflow are architectural; intermediate carries are not exposed.

## Timing
- Latency: an input word accepted at edge k appears on S with s_valid=1 during the cycle after edge k.
- Throughput: one word per cycle; a full operation takes WORDS cycles without stalls.
- Start costs one cycle: a word presented in the same cycle as start is not consumed.
- done is high exactly in the cycle the final S word is valid, and the flags are valid from that cycle.
- Reset, asynchronous and possible mid-operation:
  - state ← IDLE, carry, counter and accumulator ← 0.
  - S=0, s_valid=0, done=0, busy=0, Co=0, N=0, V=0, Z=0.
  - The aborted operation produces no done.
- A stall on the final beat delays done; the flags are not updated until that beat is accepted.

## Configuration
- MULTIWORD_ADDER_ZFLAG_EN defined: the zero accumulator and Z are implemented as described above.
- MULTIWORD_ADDER_ZFLAG_EN undefined: the accumulator is omitted and Z is tied to 0. All other behaviour is identical.

## Test plan
All scenarios use bits=4, WORDS=4, operands written as 16-bit values.
- 0x7FFF + 0x0001, cin=0, no stalls -> S words 0x0,0x0,0x0,0x8 on consecutive cycles; done with the 4th word; N=1, V=1, Co=0, Z=0.
- 0xFFFF + 0x0001, cin=0 -> all S words 0x0; Co=1, V=0, N=0, Z=1 (Z=0 without the macro).
- 0x0000 + 0x0000, cin=1 -> S words 0x1,0x0,0x0,0x0; all flags 0.
- 0x1234 + 0x4321 with in_valid low for 2 cycles after beat 2 -> S words 0x5,0x5,0x5,0x5. No s_valid during the stall; done is delayed by 2 cycles.
- start pulsed during RUN -> ignored; the operation completes with the correct sum. A start in the same cycle as done is also ignored.
- rst asserted after beat 2 -> outputs are 0 immediately and state is IDLE with no done. A fresh 0x0001+0x0001 operation then gives 0x2,0x0,0x0,0x0.

Source files
------------

// File: rtl/multiword_adder_if.sv
// rtl/multiword_adder_if.sv - operand/result bundle for the multiword adder
interface multiword_adder_if #(
  parameter int bits = 4
);
  logic            start;
  logic            cin;
  logic            in_valid;
  logic [bits-1:0] A;
  logic [bits-1:0] B;
  logic            busy;
  logic [bits-1:0] S;
  logic            s_valid;
  logic            done;
  logic            Co;
  logic            N;
  logic            V;
  logic            Z;

  // Requester side: supplies operands, observes sum and flags
  modport master (
    output start, cin, in_valid, A, B,
    input  busy, S, s_valid, done, Co, N, V, Z
  );

  // Adder side
  modport slave (
    input  start, cin, in_valid, A, B,
    output busy, S, s_valid, done, Co, N, V, Z
  );
endinterface

// File: rtl/multiword_adder.sv
// rtl/multiword_adder.sv - sequential multi-precision adder, LS word first; optional Z flag via MULTIWORD_ADDER_ZFLAG_EN
module multiword_adder #(
  parameter int bits  = 4,
  parameter int WORDS = 4
) (
  input logic              clk,
  input logic              rst,
  multiword_adder_if.slave bus
);
  localparam int            CW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic            carry, carry_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [bits-1:0] s_q, s_nx;
  logic            sv_q, sv_nx;
  logic            done_q, done_nx;
  logic            co_q, co_nx;
  logic            n_q, n_nx;
  logic            v_q, v_nx;

  // Full word sum including carry-out in the top bit
  logic [bits:0]   sum_full;
  // Sum of the low bits-1 bits; its MSB is the carry into the sign bit
  logic [bits-1:0] sum_low;
  logic            start_ok;
  logic            accept;
  logic            last_beat;

  assign sum_full  = {1'b0, bus.A} + {1'b0, bus.B} + {{bits{1'b0}}, carry};
  assign sum_low   = {1'b0, bus.A[bits-2:0]} + {1'b0, bus.B[bits-2:0]}
                   + {{(bits-1){1'b0}}, carry};
  assign start_ok  = (state == IDLE) && bus.start;
  assign accept    = (state == RUN) && bus.in_valid;
  assign last_beat = accept && (cnt == LAST);

  // State register and datapath registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      carry  <= 1'b0;
      cnt    <= '0;
      s_q    <= '0;
      sv_q   <= 1'b0;
      done_q <= 1'b0;
      co_q   <= 1'b0;
      n_q    <= 1'b0;
      v_q    <= 1'b0;
    end else begin
      state  <= state_nx;
      carry  <= carry_nx;
      cnt    <= cnt_nx;
      s_q    <= s_nx;
      sv_q   <= sv_nx;
      done_q <= done_nx;
      co_q   <= co_nx;
      n_q    <= n_nx;
      v_q    <= v_nx;
    end
  end

  // Next-state and next-datapath logic; s_valid/done are single-cycle strobes
  always_comb begin
    state_nx = state;
    carry_nx = carry;
    cnt_nx   = cnt;
    s_nx     = s_q;
    sv_nx    = 1'b0;
    done_nx  = 1'b0;
    co_nx    = co_q;
    n_nx     = n_q;
    v_nx     = v_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          carry_nx = bus.cin;
          cnt_nx   = '0;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (bus.in_valid) begin
          s_nx     = sum_full[bits-1:0];
          sv_nx    = 1'b1;
          carry_nx = sum_full[bits];
          cnt_nx   = cnt + 1'b1;
          if (cnt == LAST) begin
            // Only the most-significant word's carry and overflow are architectural
            co_nx    = sum_full[bits];
            n_nx     = sum_full[bits-1];
            v_nx     = sum_low[bits-1] ^ sum_full[bits];
            done_nx  = 1'b1;
            cnt_nx   = '0;
            state_nx = DONE;
          end
        end
      end
      DONE: begin
        // done and the final word are visible here; start is not honoured
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

`ifdef MULTIWORD_ADDER_ZFLAG_EN
  logic [bits-1:0] acc, acc_nx;
  logic            z_q, z_nx;

  // Zero accumulator: OR of every sum word of the current operation
  always_comb begin
    acc_nx = acc;
    z_nx   = z_q;
    if (start_ok) begin
      acc_nx = '0;
    end else if (accept) begin
      acc_nx = acc | sum_full[bits-1:0];
    end
    if (last_beat) begin
      z_nx = ~|(acc | sum_full[bits-1:0]);
    end
  end

  // Accumulator and Z flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      z_q <= 1'b0;
    end else begin
      acc <= acc_nx;
      z_q <= z_nx;
    end
  end

  assign bus.Z = z_q;
`else
  assign bus.Z = 1'b0;
`endif

  assign bus.busy    = (state == RUN);
  assign bus.S       = s_q;
  assign bus.s_valid = sv_q;
  assign bus.done    = done_q;
  assign bus.Co      = co_q;
  assign bus.N       = n_q;
  assign bus.V       = v_q;
endmodule
